wb_cmd_master: RTL and testbench

- Wishbone pipelined single-beat bus master that sits directly upstream of the peripheral slaves (LED block, etc.).
- Accepts one read/write command on a valid/ready interface and drives one Wishbone cycle.
- Collects ack/err/rty, or a timeout if no response arrives.
- Returns one response beat (read data + status) on a valid/ready interface.

---
 rtl/wb_cmd_master.sv | 196 +++++++++++++++++++
 tb/tb_wb_cmd_master.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/wb_cmd_master.sv
// Wishbone pipelined single-beat command master: one command in, one bus cycle, one response out.
// Define WB_CMD_MASTER_RETRY_EN to retry on rty (up to MAX_RETRY times) instead of treating it as err.
module wb_cmd_master #(
  parameter int WB_BUS_WIDTH   = 16,
  parameter int WB_ADDR_WIDTH  = 32,
  parameter int TIMEOUT_CYCLES = 255,
  parameter int MAX_RETRY      = 3,
  localparam int WB_SEL        = WB_BUS_WIDTH / 8
) (
  input  logic                     wb_clk_i,
  input  logic                     wb_reset_n_i,
  input  logic                     cmd_valid_i,
  output logic                     cmd_ready_o,
  input  logic                     cmd_we_i,
  input  logic [WB_ADDR_WIDTH-1:0] cmd_addr_i,
  input  logic [WB_BUS_WIDTH-1:0]  cmd_data_i,
  input  logic [WB_SEL-1:0]        cmd_sel_i,
  output logic                     rsp_valid_o,
  input  logic                     rsp_ready_i,
  output logic [WB_BUS_WIDTH-1:0]  rsp_data_o,
  output logic                     rsp_err_o,
  output logic                     rsp_timeout_o,
  output logic                     wb_cyc_o,
  output logic                     wb_stb_o,
  output logic                     wb_we_o,
  output logic [WB_ADDR_WIDTH-1:0] wb_addr_o,
  output logic [WB_BUS_WIDTH-1:0]  wb_data_o,
  output logic [WB_SEL-1:0]        wb_sel_o,
  output logic                     wb_lock_o,
  input  logic [WB_BUS_WIDTH-1:0]  wb_data_i,
  input  logic                     wb_ack_i,
  input  logic                     wb_err_i,
  input  logic                     wb_rty_i,
  input  logic                     wb_stall_i
);

  // S_GAP is the one-cycle cyc-low pause between a rty and the re-issued request.
  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_REQ  = 3'd1,
    S_WAIT = 3'd2,
    S_RESP = 3'd3,
    S_GAP  = 3'd4
  } state_t;

  state_t state_q, state_d;
  state_t rty_next;

  logic                     we_q, we_d;
  logic [WB_ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [WB_BUS_WIDTH-1:0]  data_q, data_d;
  logic [WB_SEL-1:0]        sel_q, sel_d;
  logic [WB_BUS_WIDTH-1:0]  rdata_q, rdata_d;
  logic                     err_q, err_d;
  logic                     to_q, to_d;
  logic [15:0]              tcnt_q, tcnt_d;
  logic                     expired;

  // tcnt_q counts cycles already spent with cyc high in this attempt
  assign expired = (tcnt_q == 16'(TIMEOUT_CYCLES - 1));

`ifdef WB_CMD_MASTER_RETRY_EN
  localparam int RW = $clog2(MAX_RETRY + 1) + 1;
  logic [RW-1:0] retry_q, retry_d;
  logic          retry_exhausted;

  assign retry_exhausted = (retry_q == RW'(MAX_RETRY));
  assign rty_next        = retry_exhausted ? S_RESP : S_GAP;

  always_ff @(posedge wb_clk_i or negedge wb_reset_n_i) begin
    if (!wb_reset_n_i) retry_q <= '0;
    else               retry_q <= retry_d;
  end
`else
  assign rty_next = S_RESP;
`endif

  always_ff @(posedge wb_clk_i or negedge wb_reset_n_i) begin
    if (!wb_reset_n_i) state_q <= S_IDLE;
    else               state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: if (cmd_valid_i) state_d = S_REQ;
      S_REQ, S_WAIT: begin
        if (wb_err_i)                              state_d = S_RESP;
        else if (wb_rty_i)                         state_d = rty_next;
        else if (wb_ack_i || expired)              state_d = S_RESP;
        else if (state_q == S_REQ && !wb_stall_i)  state_d = S_WAIT;
      end
      S_GAP:  state_d = S_REQ;
      S_RESP: if (rsp_ready_i) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    cmd_ready_o = wb_reset_n_i && (state_q == S_IDLE);
    rsp_valid_o = (state_q == S_RESP);
    wb_cyc_o    = (state_q == S_REQ) || (state_q == S_WAIT);
    wb_stb_o    = (state_q == S_REQ);
  end

  always_ff @(posedge wb_clk_i or negedge wb_reset_n_i) begin
    if (!wb_reset_n_i) begin
      we_q    <= 1'b0;
      addr_q  <= '0;
      data_q  <= '0;
      sel_q   <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
      to_q    <= 1'b0;
      tcnt_q  <= '0;
    end else begin
      we_q    <= we_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
      sel_q   <= sel_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
      to_q    <= to_d;
      tcnt_q  <= tcnt_d;
    end
  end

  always_comb begin
    we_d    = we_q;
    addr_d  = addr_q;
    data_d  = data_q;
    sel_d   = sel_q;
    rdata_d = rdata_q;
    err_d   = err_q;
    to_d    = to_q;
    tcnt_d  = tcnt_q;
`ifdef WB_CMD_MASTER_RETRY_EN
    retry_d = retry_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (cmd_valid_i) begin
          we_d    = cmd_we_i;
          addr_d  = cmd_addr_i;
          data_d  = cmd_data_i;
          sel_d   = cmd_sel_i;
          rdata_d = '0;
          err_d   = 1'b0;
          to_d    = 1'b0;
          tcnt_d  = '0;
`ifdef WB_CMD_MASTER_RETRY_EN
          retry_d = '0;
`endif
        end
      end
      S_REQ, S_WAIT: begin
        tcnt_d = tcnt_q + 16'd1;
        if (wb_err_i) begin
          err_d   = 1'b1;
          rdata_d = '0;
        end else if (wb_rty_i) begin
`ifdef WB_CMD_MASTER_RETRY_EN
          if (retry_exhausted) begin
            err_d   = 1'b1;
            rdata_d = '0;
          end else begin
            retry_d = retry_q + 1'b1;
          end
`else
          err_d   = 1'b1;
          rdata_d = '0;
`endif
        end else if (wb_ack_i) begin
          err_d   = 1'b0;
          rdata_d = we_q ? '0 : wb_data_i;
        end else if (expired) begin
          err_d   = 1'b1;
          to_d    = 1'b1;
          rdata_d = '0;
        end
      end
      S_GAP: tcnt_d = '0;
      default: ;
    endcase
  end

  assign wb_we_o       = we_q;
  assign wb_addr_o     = addr_q;
  assign wb_data_o     = data_q;
  assign wb_sel_o      = sel_q;
  assign wb_lock_o     = 1'b0;
  assign rsp_data_o    = rdata_q;
  assign rsp_err_o     = err_q;
  assign rsp_timeout_o = to_q;

endmodule

// File: tb/tb_wb_cmd_master.sv
// Bench for wb_cmd_master: reactive Wishbone slave plus a transaction-level model of cycle counts and response.
module tb_wb_cmd_master;
  localparam int TO = 8;
  localparam int MR = 3;
`ifdef WB_CMD_MASTER_RETRY_EN
  localparam bit RETRY_EN = 1'b1;
`else
  localparam bit RETRY_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n;
  logic        cmd_valid, cmd_ready, cmd_we;
  logic [31:0] cmd_addr;
  logic [15:0] cmd_data;
  logic [1:0]  cmd_sel;
  logic        rsp_valid, rsp_ready, rsp_err, rsp_timeout;
  logic [15:0] rsp_data;
  logic        wb_cyc, wb_stb, wb_we, wb_lock;
  logic [31:0] wb_addr;
  logic [15:0] wb_dout, wb_din;
  logic [1:0]  wb_sel;
  logic        wb_ack, wb_err, wb_rty, wb_stall;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  wb_cmd_master #(
    .WB_BUS_WIDTH(16), .WB_ADDR_WIDTH(32), .TIMEOUT_CYCLES(TO), .MAX_RETRY(MR)
  ) dut (
    .wb_clk_i(clk), .wb_reset_n_i(rst_n),
    .cmd_valid_i(cmd_valid), .cmd_ready_o(cmd_ready), .cmd_we_i(cmd_we),
    .cmd_addr_i(cmd_addr), .cmd_data_i(cmd_data), .cmd_sel_i(cmd_sel),
    .rsp_valid_o(rsp_valid), .rsp_ready_i(rsp_ready), .rsp_data_o(rsp_data),
    .rsp_err_o(rsp_err), .rsp_timeout_o(rsp_timeout),
    .wb_cyc_o(wb_cyc), .wb_stb_o(wb_stb), .wb_we_o(wb_we),
    .wb_addr_o(wb_addr), .wb_data_o(wb_dout), .wb_sel_o(wb_sel), .wb_lock_o(wb_lock),
    .wb_data_i(wb_din), .wb_ack_i(wb_ack), .wb_err_i(wb_err), .wb_rty_i(wb_rty),
    .wb_stall_i(wb_stall)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic clear_slave();
    wb_ack = 1'b0; wb_err = 1'b0; wb_rty = 1'b0; wb_stall = 1'b0;
  endtask

  // kind: 0 no response, 1 ack, 2 err, 3 rty, 4 err+ack, 5 rty+ack; first nrty terminations are plain rty
  task automatic run_txn(input logic we, input logic [31:0] addr, input logic [15:0] data,
                         input logic [1:0] sel, input int stall_n, input int delay,
                         input int nrty, input int kind, input logic [15:0] rdata, input int hold);
    int e_lat, e_cyc, e_stb, e_taken, used, rl, d, ek;
    logic e_err, e_to;
    logic [15:0] e_data;
    bit done;
    int c, lat, cyc_n, stb_n, taken, stall_left, pend, rty_left, tk;
    bit prev_cyc, stall, bad_ready, bad_bus, bad_hold;
    logic [15:0] h_data;
    logic h_err, h_to;

    e_lat = 0; e_cyc = 0; e_stb = 0; e_taken = 0; used = 0; rl = nrty; done = 0;
    e_err = 1'b0; e_to = 1'b0; e_data = '0;
    while (!done) begin
      d  = stall_n + 1 + delay;
      ek = (rl > 0) ? 3 : kind;
      e_stb += (stall_n + 1 < TO) ? stall_n + 1 : TO;
      if (ek == 0 || d > TO) begin
        e_cyc += TO; e_lat += TO;
        if (stall_n + 1 <= TO) e_taken++;
        e_err = 1'b1; e_to = 1'b1; done = 1;
      end else begin
        e_cyc += d; e_lat += d; e_taken++;
        if (rl > 0) rl--;
        if (RETRY_EN && (ek == 3 || ek == 5)) begin
          if (used < MR) begin used++; e_lat++; end
          else begin e_err = 1'b1; done = 1; end
        end else if (ek == 1) begin
          e_data = we ? 16'h0 : rdata; done = 1;
        end else begin
          e_err = 1'b1; done = 1;
        end
      end
    end
    e_lat += 1;

    @(negedge clk);
    check("cmd_ready_idle", 32'(cmd_ready), 32'd1);
    cmd_valid = 1'b1; cmd_we = we; cmd_addr = addr; cmd_data = data; cmd_sel = sel;
    @(posedge clk);
    @(negedge clk);
    cmd_valid = 1'b0; cmd_we = ~we; cmd_addr = ~addr; cmd_data = ~data; cmd_sel = ~sel;

    c = 0; lat = 0; cyc_n = 0; stb_n = 0; taken = 0; stall_left = 0; pend = -1;
    rty_left = nrty; prev_cyc = 0; bad_ready = 0; bad_bus = 0;
    while (lat == 0 && c < 200) begin
      c++;
      if (rsp_valid) lat = c;
      else begin
        if (cmd_ready) bad_ready = 1;
        if (wb_cyc && !prev_cyc) begin stall_left = stall_n; pend = -1; end
        prev_cyc = wb_cyc;
        stall = wb_stb && stall_left > 0;
        if (stall) stall_left--;
        if (wb_cyc) cyc_n++;
        if (wb_stb) begin
          stb_n++;
          if (wb_addr !== addr || wb_we !== we || wb_dout !== data || wb_sel !== sel) bad_bus = 1;
        end
        if (wb_stb && !stall) begin taken++; pend = delay; end
        clear_slave();
        wb_stall = stall;
        wb_din   = 16'($urandom);
        if (wb_cyc && pend == 0) begin
          tk = (rty_left > 0) ? 3 : kind;
          if (rty_left > 0) rty_left--;
          wb_ack = (tk == 1 || tk == 4 || tk == 5);
          wb_err = (tk == 2 || tk == 4);
          wb_rty = (tk == 3 || tk == 5);
          wb_din = rdata;
          pend = -1;
        end else if (pend > 0) pend--;
        @(posedge clk);
        @(negedge clk);
      end
    end
    clear_slave();

    check("latency", 32'(lat), 32'(e_lat));
    check("cyc_cycles", 32'(cyc_n), 32'(e_cyc));
    check("stb_cycles", 32'(stb_n), 32'(e_stb));
    check("req_taken", 32'(taken), 32'(e_taken));
    check("ready_low_busy", 32'(bad_ready), 32'd0);
    check("bus_stable", 32'(bad_bus), 32'd0);
    check("rsp_err", 32'(rsp_err), 32'(e_err));
    check("rsp_timeout", 32'(rsp_timeout), 32'(e_to));
    check("rsp_data", 32'(rsp_data), 32'(e_data));

    h_data = rsp_data; h_err = rsp_err; h_to = rsp_timeout; bad_hold = 0;
    rsp_ready = 1'b0;
    for (int i = 0; i < hold; i++) begin
      wb_ack = 1'($urandom); wb_err = 1'($urandom); wb_rty = 1'($urandom);
      wb_din = 16'($urandom);
      @(posedge clk);
      @(negedge clk);
      if (rsp_valid !== 1'b1 || rsp_data !== h_data || rsp_err !== h_err ||
          rsp_timeout !== h_to || cmd_ready !== 1'b0 || wb_cyc !== 1'b0) bad_hold = 1;
    end
    clear_slave();
    check("rsp_hold_stable", 32'(bad_hold), 32'd0);
    rsp_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rsp_ready = 1'b0;
    check("rsp_valid_drop", 32'(rsp_valid), 32'd0);
    check("cmd_ready_back", 32'(cmd_ready), 32'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, observed running expected done");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0; cmd_valid = 1'b0; cmd_we = 1'b0; cmd_addr = '0; cmd_data = '0; cmd_sel = '0;
    rsp_ready = 1'b0; wb_din = '0;
    clear_slave();
    @(negedge clk);
    @(negedge clk);
    check("rst_cmd_ready", 32'(cmd_ready), 32'd0);
    check("rst_cyc", 32'(wb_cyc), 32'd0);
    check("rst_stb", 32'(wb_stb), 32'd0);
    check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    check("rst_lock", 32'(wb_lock), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);
    check("post_rst_ready", 32'(cmd_ready), 32'd1);

    run_txn(1'b1, 32'h00A0, 16'hBEEF, 2'b11, 0, 1, 0, 1, 16'h1234, 0);
    run_txn(1'b0, 32'h00A0, 16'h0000, 2'b11, 0, 1, 0, 1, 16'hBEEF, 5);
    run_txn(1'b0, 32'h0010, 16'h5555, 2'b01, 4, 1, 0, 1, 16'hCAFE, 1);
    run_txn(1'b0, 32'h0020, 16'h0000, 2'b10, 0, 1, 0, 0, 16'h0000, 3);
    run_txn(1'b0, 32'h0030, 16'h0000, 2'b11, 0, 1, 0, 4, 16'hA5A5, 0);
    run_txn(1'b0, 32'h0040, 16'h0000, 2'b11, 0, 0, 0, 1, 16'h7E57, 0);
    run_txn(1'b0, 32'h0050, 16'h0000, 2'b11, 0, TO - 1, 0, 1, 16'h0F0F, 0);
    run_txn(1'b0, 32'h0060, 16'h0000, 2'b11, 2, TO - 2, 0, 1, 16'h0F0F, 0);
    run_txn(1'b1, 32'h0070, 16'h1111, 2'b11, 9, 1, 0, 1, 16'h2222, 0);
`ifdef WB_CMD_MASTER_RETRY_EN
    run_txn(1'b0, 32'h0080, 16'h0000, 2'b11, 0, 1, 2, 1, 16'h3C3C, 0);
    run_txn(1'b0, 32'h0090, 16'h0000, 2'b11, 0, 1, 4, 1, 16'h3C3C, 0);
`else
    run_txn(1'b0, 32'h0080, 16'h0000, 2'b11, 0, 1, 0, 3, 16'h3C3C, 0);
    run_txn(1'b0, 32'h0090, 16'h0000, 2'b11, 0, 1, 0, 5, 16'h3C3C, 0);
`endif

    // reset while a request is stalled on the bus
    @(negedge clk);
    cmd_valid = 1'b1; cmd_we = 1'b1; cmd_addr = 32'h00F0; cmd_data = 16'h9999; cmd_sel = 2'b11;
    @(posedge clk);
    @(negedge clk);
    cmd_valid = 1'b0; wb_stall = 1'b1;
    @(negedge clk);
    check("pre_rst_cyc", 32'(wb_cyc), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    check("midrst_cyc", 32'(wb_cyc), 32'd0);
    check("midrst_stb", 32'(wb_stb), 32'd0);
    check("midrst_ready", 32'(cmd_ready), 32'd0);
    check("midrst_rsp_valid", 32'(rsp_valid), 32'd0);
    @(negedge clk);
    rst_n = 1'b1; wb_stall = 1'b0;
    @(negedge clk);
    check("midrst_idle_ready", 32'(cmd_ready), 32'd1);
    check("midrst_idle_cyc", 32'(wb_cyc), 32'd0);

    for (int i = 0; i < 40; i++) begin
      run_txn(1'($urandom_range(0, 1)), $urandom, 16'($urandom), 2'($urandom_range(0, 3)),
              int'($urandom_range(0, 3)), int'($urandom_range(0, 6)),
              RETRY_EN ? int'($urandom_range(0, 4)) : 0, int'($urandom_range(0, 5)),
              16'($urandom), int'($urandom_range(0, 3)));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
